// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: groups the instruction-memory handshake, the decode and
// redirect inputs, and the PC outputs of the program-counter sequencer.
// The master modport is the sequencer's view. The slave modport is the view
// of the surrounding core (decode, branch resolution and the memory port).
interface pc_sequencer_if;
    logic        stall;
    logic        branch_taken;
    logic        jump;
    logic        jump_reg;
    logic [15:0] field_addr16;
    logic [25:0] field_addr26;
    logic [31:0] reg_target;
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        exc_misaligned;

    modport master (
        input  stall,
        input  branch_taken,
        input  jump,
        input  jump_reg,
        input  field_addr16,
        input  field_addr26,
        input  reg_target,
        input  imem_ack,
        output imem_req,
        output imem_addr,
        output pc,
        output pc_plus4,
        output instr_valid,
        output exc_misaligned
    );

    modport slave (
        output stall,
        output branch_taken,
        output jump,
        output jump_reg,
        output field_addr16,
        output field_addr26,
        output reg_target,
        output imem_ack,
        input  imem_req,
        input  imem_addr,
        input  pc,
        input  pc_plus4,
        input  instr_valid,
        input  exc_misaligned
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC of the multicycle MIPS core.
// It fetches each instruction over a req/ack handshake and holds it for
// decode. It then selects the next PC with the priority
// jump_reg > jump > branch > sequential.
// A misaligned register jump parks the sequencer in FAULT until reset.
// Every output comes from registered state only. The redirect inputs
// therefore reach the outputs only after the advance edge.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst_n,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        FAULT = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        exc_q, exc_d;

    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;
    logic        jr_misaligned;

    // Candidate targets and the fixed-priority next-PC selection.
    // pc_plus4_q is kept as its own register, so the branch and jump
    // targets need only one adder after the state.
    always_comb begin
        branch_target = pc_plus4_q + {{14{bus.field_addr16[15]}}, bus.field_addr16, 2'b00};
        jump_target   = {pc_plus4_q[31:28], bus.field_addr26, 2'b00};
        jr_misaligned = bus.jump_reg && (bus.reg_target[1:0] != 2'b00);
        if (bus.jump_reg) begin
            next_pc = bus.reg_target;
        end else if (bus.jump) begin
            next_pc = jump_target;
        end else if (bus.branch_taken) begin
            next_pc = branch_target;
        end else begin
            next_pc = pc_plus4_q;
        end
    end

    // Next-state logic. The PC changes only on an unstalled ISSUE advance.
    // A misaligned register target leaves the PC untouched and enters FAULT.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        exc_d      = exc_q;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.stall) begin
                    if (jr_misaligned) begin
                        exc_d   = 1'b1;
                        state_d = FAULT;
                    end else begin
                        pc_d       = next_pc;
                        pc_plus4_d = next_pc + 32'd4;
                        state_d    = FETCH;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State, PC and sticky-exception registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pc_plus4_q <= RESET_PC + 32'd4;
            exc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            exc_q      <= exc_d;
        end
    end

    assign bus.imem_req       = (state_q == FETCH);
    assign bus.imem_addr      = pc_q;
    assign bus.pc             = pc_q;
    assign bus.pc_plus4       = pc_plus4_q;
    assign bus.instr_valid    = (state_q == ISSUE);
    assign bus.exc_misaligned = exc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized and directed stimulus for pc_sequencer.
// A behavioural model built from the fetch/issue rules predicts every output.
// A negedge compare process checks the DUT against that model on every cycle.
// Literal expectations from hand-worked examples pin both the DUT and the model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock with a 10-time-unit period.
    always #5 clk = ~clk;

    // Model state: the expected PC and which phase the sequencer should be in.
    logic [31:0] expPc       = RESET_PC;
    bit          bootPending = 1'b1;
    bit          expReq      = 1'b0;
    bit          expValid    = 1'b0;
    bit          expExc      = 1'b0;

    // Next PC from the architectural rules, using plain 32-bit arithmetic.
    function automatic logic [31:0] nextPcModel(input logic [31:0] curPc, input logic br, input logic j,
                                                input logic jr, input logic [15:0] a16,
                                                input logic [25:0] a26, input logic [31:0] rt);
        logic [31:0] seq;
        int          off;
        seq = curPc + 32'd4;
        off = int'($signed(a16));
        if (jr) return rt;
        if (j) return (seq & 32'hF000_0000) | (32'(a26) << 2);
        if (br) return seq + 32'(off * 4);
        return seq;
    endfunction

    // Behavioural reference model: after boot, fetch until ack.
    // Then hold the instruction until an unstalled cycle, which redirects or faults.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expPc       <= RESET_PC;
            bootPending <= 1'b1;
            expReq      <= 1'b0;
            expValid    <= 1'b0;
            expExc      <= 1'b0;
        end else if (bootPending) begin
            bootPending <= 1'b0;
            expReq      <= 1'b1;
        end else if (expReq) begin
            if (bus.imem_ack) begin
                expReq   <= 1'b0;
                expValid <= 1'b1;
            end
        end else if (expValid && !bus.stall) begin
            expValid <= 1'b0;
            if (bus.jump_reg && (bus.reg_target % 4 != 0)) begin
                expExc <= 1'b1;
            end else begin
                expPc  <= nextPcModel(expPc, bus.branch_taken, bus.jump, bus.jump_reg,
                                      bus.field_addr16, bus.field_addr26, bus.reg_target);
                expReq <= 1'b1;
            end
        end
    end

    // Single comparison point: counts every check and reports each failure.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        checkOutput("imem_req", 32'(bus.imem_req), 32'(expReq));
        checkOutput("instr_valid", 32'(bus.instr_valid), 32'(expValid));
        checkOutput("exc_misaligned", 32'(bus.exc_misaligned), 32'(expExc));
        checkOutput("pc", bus.pc, expPc);
        checkOutput("imem_addr", bus.imem_addr, expPc);
        checkOutput("pc_plus4", bus.pc_plus4, expPc + 32'd4);
    end

    // Drive one cycle of inputs on the falling edge, then return just after the next rising edge.
    task automatic applyStimulus(input logic s, input logic br, input logic j, input logic jr,
                                 input logic [15:0] a16, input logic [25:0] a26,
                                 input logic [31:0] rt, input logic ack);
        @(negedge clk);
        bus.stall        = s;
        bus.branch_taken = br;
        bus.jump         = j;
        bus.jump_reg     = jr;
        bus.field_addr16 = a16;
        bus.field_addr26 = a26;
        bus.reg_target   = rt;
        bus.imem_ack     = ack;
        @(posedge clk);
        #1;
    endtask

    // Acknowledge fetches until the model says an instruction is held, within a cycle budget.
    task automatic advanceToIssue();
        int n;
        n = 0;
        while (!expValid && n < 20) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1);
            n++;
        end
        if (!expValid) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL advance_timeout: got no held instruction, expected one within 20 cycles");
        end
    endtask

    // Steer the PC to an aligned address with a register jump.
    task automatic redirectTo(input logic [31:0] addr);
        advanceToIssue();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, addr, 1'b0);
        checkOutput("redirect_pc", bus.pc, addr);
    endtask

    // Global time limit so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected completion before the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rt;
        logic [31:0] holdAddr;

        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        bus.jump         = 1'b0;
        bus.jump_reg     = 1'b0;
        bus.field_addr16 = 16'h0;
        bus.field_addr26 = 26'h0;
        bus.reg_target   = 32'h0;
        bus.imem_ack     = 1'b1;

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_req", 32'(bus.imem_req), 32'd0);
        checkOutput("rst_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("rst_exc", 32'(bus.exc_misaligned), 32'd0);
        checkOutput("rst_pc", bus.pc, 32'h0000_0000);
        checkOutput("rst_pc_plus4", bus.pc_plus4, 32'h0000_0004);
        repeat (2) @(posedge clk);

        // Sequential fetch with ack tied high: pc 0,0,4,4,8,8,12,12
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("boot_req", 32'(bus.imem_req), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            checkOutput("seq_req", 32'(bus.imem_req), 32'(k % 2));
            checkOutput("seq_valid", 32'(bus.instr_valid), 32'((k + 1) % 2));
            checkOutput("seq_pc", bus.pc, 32'(((k - 1) / 2) * 4));
            checkOutput("model_seq_pc", expPc, 32'(((k - 1) / 2) * 4));
        end

        // Backward then forward branch from 0x100
        redirectTo(32'h0000_0100);
        advanceToIssue();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE, 26'h0, 32'h0, 1'b0);
        checkOutput("branch_back_addr", bus.imem_addr, 32'h0000_00FC);
        checkOutput("branch_back_req", 32'(bus.imem_req), 32'd1);
        checkOutput("model_branch_back", expPc, 32'h0000_00FC);
        redirectTo(32'h0000_0100);
        advanceToIssue();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0003, 26'h0, 32'h0, 1'b0);
        checkOutput("branch_fwd_addr", bus.imem_addr, 32'h0000_0110);
        checkOutput("model_branch_fwd", expPc, 32'h0000_0110);

        // Jump beats branch, then jump_reg beats jump
        redirectTo(32'h9000_0010);
        advanceToIssue();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 26'h0000040, 32'h0, 1'b0);
        checkOutput("jump_pc", bus.pc, 32'h9000_0100);
        checkOutput("model_jump", expPc, 32'h9000_0100);
        advanceToIssue();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 26'h0000040, 32'h0000_0400, 1'b0);
        checkOutput("jr_pc", bus.pc, 32'h0000_0400);

        // Late ack: imem_addr is held while the request waits
        holdAddr = bus.imem_addr;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0000123, 32'h0, 1'b0);
            checkOutput("wait_addr", bus.imem_addr, holdAddr);
            checkOutput("wait_req", 32'(bus.imem_req), 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1);
        checkOutput("late_ack_valid", 32'(bus.instr_valid), 32'd1);

        // Stall with a jump asserted: nothing moves until the first unstalled edge
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0000123, 32'h0, 1'b1);
            checkOutput("stall_pc", bus.pc, 32'h0000_0400);
            checkOutput("stall_pc_plus4", bus.pc_plus4, 32'h0000_0404);
            checkOutput("stall_valid", 32'(bus.instr_valid), 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0000123, 32'h0, 1'b0);
        checkOutput("unstall_pc", bus.pc, 32'h0000_048C);
        checkOutput("unstall_req", 32'(bus.imem_req), 32'd1);

        // Wrap: 0xFFFFFFFC plus 4 is 0
        redirectTo(32'hFFFF_FFFC);
        checkOutput("wrap_pre_plus4", bus.pc_plus4, 32'h0000_0000);
        advanceToIssue();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        checkOutput("wrap_pc", bus.pc, 32'h0000_0000);
        checkOutput("wrap_pc_plus4", bus.pc_plus4, 32'h0000_0004);

        // Async reset in the middle of a FETCH cycle
        checkOutput("prereset_req", 32'(bus.imem_req), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_req", 32'(bus.imem_req), 32'd0);
        checkOutput("async_pc", bus.pc, RESET_PC);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic; register-jump targets are kept aligned here
        for (int i = 0; i < 400; i++) begin
            rt = $urandom & 32'hFFFF_FFFC;
            applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 7) == 0),
                          16'($urandom), 26'($urandom), rt, 1'($urandom_range(0, 2) != 0));
        end

        // Misaligned register jump: sticky fault, PC frozen until reset
        redirectTo(32'h0000_0800);
        advanceToIssue();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0, 26'h0, 32'h0000_0402, 1'b0);
        checkOutput("fault_exc", 32'(bus.exc_misaligned), 32'd1);
        checkOutput("fault_pc", bus.pc, 32'h0000_0800);
        checkOutput("model_fault_exc", 32'(expExc), 32'd1);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1, 16'($urandom), 26'($urandom),
                          32'h0000_0004, 1'b1);
            checkOutput("fault_req", 32'(bus.imem_req), 32'd0);
            checkOutput("fault_valid", 32'(bus.instr_valid), 32'd0);
            checkOutput("fault_hold_pc", bus.pc, 32'h0000_0800);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("clear_exc", 32'(bus.exc_misaligned), 32'd0);
        checkOutput("clear_pc", bus.pc, RESET_PC);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
